led_pattern_monitor: RTL and testbench
======================================

Name: led_pattern_monitor

Overview:
- Reader side of the LED pattern generators: samples the 8-bit LED bus and identifies which of the four shift patterns is running (dot right, dot left, fill right, fill left).
- Locks onto the detected pattern, checks every subsequent step, counts completed sweeps and flags illegal steps.
- Used as an on-chip checker beside the LED drivers and as a bench monitor.

Parameters:
CNT_W, 8, width of sweep_cnt (wraps)
ERR_W, 4, width of err_cnt (saturates)
STALL_MAX, 16, identical consecutive samples tolerated before stall (optional feature only)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
SS  input  1  sample enable; LED8 evaluated only on cycles with SS=1
LED8  input  8  observed LED bus, synchronous to clk
locked  output  1  a pattern is locked
pat  output  2  locked pattern: 0 dot right (x==00?80:x>>1), 1 dot left (x==00?01:x<<1), 2 fill left (x==FF?00:(x>>1)|80), 3 fill right (x==FF?00:(x<<1)|01)
pos  output  4  position of last accepted sample
step  output  1  one-cycle pulse on a valid locked step
err  output  1  one-cycle pulse on an illegal step
sweep_cnt  output  CNT_W  completed sweeps
err_cnt  output  ERR_W  saturating error count
stall  output  1  stall flag (optional feature)

Behaviour:
- Reset: synchronous, active-high. prev=00, state HUNT, locked=0, pat=0, pos=0, step=0, err=0, sweep_cnt=0, err_cnt=0, stall=0. Reset wins over SS in the same cycle.
- All outputs are registered and update on the edge that samples LED8 (one-cycle latency). step and err are high for exactly one cycle.
- Samples with SS=0 are ignored: no state, counter or output change, and step/err stay 0.
- Next functions: N0..N3 are the per-pattern successor functions defined under pat. All shifts are 8-bit and truncated; 01>>1=00 and 80<<1=00.
- HUNT state, sample cur with cur==prev: ignored.
- HUNT state, cur!=prev: match = set of k where Nk(prev)==cur.
  - Exactly one match: go to LOCK, pat=k, step=1.
  - Two matches (00->80 gives {0,2}; 00->01 gives {1,3}): stay in HUNT.
  - No match: err=1, err_cnt+1, stay in HUNT.
  - In every case prev<=cur.
- LOCK state, cur==prev: hold (generator paused). No step, no err.
- LOCK state, cur==N[pat](prev): step=1, prev<=cur. If cur==00, sweep_cnt+1 (wraps modulo 2^CNT_W).
- LOCK state, any other value: err=1, err_cnt+1 (saturates at all-ones), go to HUNT, locked=0, prev<=cur. Re-locking then starts from the bad value.
- locked=1 exactly while in LOCK. pat holds its last value while in HUNT.
- pos update on every accepted sample (any sample with cur!=prev):
  - Dot patterns (pat 0/1, LOCK): index of the set bit 0..7, or 8 for 00.
  - Fill patterns (pat 2/3, LOCK): popcount 0..8.
  - HUNT: popcount.
- Sweep counting applies to the transition into 00 only while in LOCK, including the step that produces the lock.

Optional Feature:
- LED_MON_STALL_EN defined:
  - Counter of consecutive LOCK-state samples with cur==prev; counts only while SS=1.
  - stall<=1 when the count reaches STALL_MAX; the counter saturates there.
  - A valid step, an error, or reset clears the counter and stall.
  - Lock state is unaffected.
- Not defined: stall is tied to 0 and no counter logic exists.

Test Plan:
- Reset, SS=1, LED8 = 80,40,20,10,08,04,02,01,00,80 -> lock on 40 with pat=0; step each sample after the first; pos=0 at 01, pos=8 at 00; sweep_cnt=1 after 00; err_cnt=0.
- Reset, LED8 = 01,03,07,0F,1F,3F,7F,FF,00 -> lock at 03 with pat=3; pos=8 at FF; sweep_cnt=1 at 00.
- Dot right locked at 20, then inject 24 -> err pulse, locked=0, err_cnt=1. Then 12,09 -> re-lock at 12 with pat=0 (N0(24)=12), step pulses, no further err.
- Locked at 10 with SS=0 while LED8 toggles randomly for 5 cycles -> no output change. Then SS=1 with 10 repeated 3 times -> no step, no err.
- Locked mid-sweep: reset=1 and SS=1 in the same cycle with LED8=08 -> next cycle all outputs at reset values, state HUNT.
- With LED_MON_STALL_EN and STALL_MAX=4: locked, then 4 identical samples -> stall=1 after the 4th. Next valid step -> stall=0.

Source files
------------

// File: rtl/led_pattern_monitor.sv
// LED bus monitor: identifies which of four shift patterns is running, locks onto it and checks each step.
// Optional stall detection on a paused locked generator is enabled by defining LED_MON_STALL_EN.
module led_pattern_monitor #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ERR_W     = 4,
  parameter int unsigned STALL_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SS,
  input  logic [7:0]       LED8,
  output logic             locked,
  output logic [1:0]       pat,
  output logic [3:0]       pos,
  output logic             step,
  output logic             err,
  output logic [CNT_W-1:0] sweep_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             stall
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t     state;
  logic [7:0] prev;

  // Successor of x under pattern k
  function automatic logic [7:0] succ(input logic [1:0] k, input logic [7:0] x);
    logic [7:0] r;
    case (k)
      2'd0:    r = (x == 8'h00) ? 8'h80 : (x >> 1);
      2'd1:    r = (x == 8'h00) ? 8'h01 : (x << 1);
      2'd2:    r = (x == 8'hFF) ? 8'h00 : ((x >> 1) | 8'h80);
      default: r = (x == 8'hFF) ? 8'h00 : ((x << 1) | 8'h01);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] ones(input logic [7:0] x);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + 4'(x[i]);
    return n;
  endfunction

  // Highest set bit index, 8 when empty
  function automatic logic [3:0] top_bit(input logic [7:0] x);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 0; i < 8; i++) if (x[i]) r = 4'(i);
    return r;
  endfunction

  logic [2:0] match_n_c;
  logic [1:0] match_idx_c;
  logic       changed_c;
  logic       good_c;
  logic       step_c;
  logic       err_c;
  logic [1:0] next_pat_c;
  logic [3:0] pos_c;

  always_comb begin
    match_n_c   = 3'd0;
    match_idx_c = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (succ(2'(k), prev) == LED8) begin
        match_n_c   = match_n_c + 3'd1;
        match_idx_c = 2'(k);
      end
    end
    changed_c  = (LED8 != prev);
    good_c     = (LED8 == succ(pat, prev));
    step_c     = SS && changed_c && ((state == LOCK) ? good_c  : (match_n_c == 3'd1));
    err_c      = SS && changed_c && ((state == LOCK) ? !good_c : (match_n_c == 3'd0));
    next_pat_c = (state == LOCK) ? pat : match_idx_c;
    // Dot patterns report bit position only once locked; otherwise fill level
    pos_c      = (step_c && !next_pat_c[1]) ? top_bit(LED8) : ones(LED8);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      prev      <= 8'h00;
      locked    <= 1'b0;
      pat       <= 2'd0;
      pos       <= 4'd0;
      step      <= 1'b0;
      err       <= 1'b0;
      sweep_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      step <= step_c;
      err  <= err_c;
      if (SS && changed_c) begin
        prev <= LED8;
        pos  <= pos_c;
      end
      if (step_c) begin
        state  <= LOCK;
        locked <= 1'b1;
        pat    <= next_pat_c;
        if (LED8 == 8'h00) sweep_cnt <= sweep_cnt + CNT_W'(1);
      end
      if (err_c) begin
        state  <= HUNT;
        locked <= 1'b0;
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

`ifdef LED_MON_STALL_EN
  localparam int unsigned SW = $clog2(STALL_MAX + 1);

  logic [SW-1:0] hold_cnt;

  // Consecutive repeated samples while locked
  always_ff @(posedge clk) begin
    if (reset || step_c || err_c) begin
      hold_cnt <= '0;
      stall    <= 1'b0;
    end else if (SS && (state == LOCK) && !changed_c && (hold_cnt != SW'(STALL_MAX))) begin
      hold_cnt <= hold_cnt + SW'(1);
      if (hold_cnt == SW'(STALL_MAX - 1)) stall <= 1'b1;
    end
  end
`else
  logic stall_unused;
  assign stall_unused = 1'(STALL_MAX);
  assign stall        = 1'b0;
`endif

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Bench for led_pattern_monitor: rule-level reference model compared every cycle, plus literal checkpoints.
module tb_led_pattern_monitor;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned ERR_W     = 4;
  localparam int unsigned STALL_MAX = 4;

  logic             clk = 1'b0;
  logic             reset, SS;
  logic [7:0]       LED8;
  logic             locked, step, err, stall;
  logic [1:0]       pat;
  logic [3:0]       pos;
  logic [CNT_W-1:0] sweep_cnt;
  logic [ERR_W-1:0] err_cnt;

  always #5 clk = ~clk;

  led_pattern_monitor #(.CNT_W(CNT_W), .ERR_W(ERR_W), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .reset(reset), .SS(SS), .LED8(LED8), .locked(locked), .pat(pat),
    .pos(pos), .step(step), .err(err), .sweep_cnt(sweep_cnt), .err_cnt(err_cnt), .stall(stall)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern rules in plain arithmetic
  function automatic int succ(input int k, input int x);
    case (k)
      0:       return (x == 0)   ? 128 : x / 2;
      1:       return (x == 0)   ? 1   : (x * 2) % 256;
      2:       return (x == 255) ? 0   : x / 2 + 128;
      default: return (x == 255) ? 0   : (x * 2) % 256 + 1;
    endcase
  endfunction

  function automatic int hibit(input int x);
    for (int i = 7; i >= 0; i--) if (((x >> i) & 1) == 1) return i;
    return 8;
  endfunction

  int m_prev, m_pat, m_pos, m_sweep, m_errc, m_hold;
  bit m_lock, m_step, m_err, m_stall;

  always @(posedge clk) begin
    int cur, n, newpat;
    bit good, bad;
    if (reset) begin
      m_prev = 0; m_lock = 0; m_pat = 0; m_pos = 0; m_step = 0; m_err = 0;
      m_sweep = 0; m_errc = 0; m_hold = 0; m_stall = 0;
    end else begin
      m_step = 0; m_err = 0;
      if (SS) begin
        cur = int'(LED8);
        if (cur == m_prev) begin
`ifdef LED_MON_STALL_EN
          if (m_lock && m_hold < STALL_MAX) begin
            m_hold++;
            if (m_hold == STALL_MAX) m_stall = 1;
          end
`endif
        end else begin
          newpat = m_pat;
          if (m_lock) begin
            good = (succ(m_pat, m_prev) == cur);
            bad  = !good;
          end else begin
            n = 0;
            for (int k = 0; k < 4; k++) if (succ(k, m_prev) == cur) begin n++; newpat = k; end
            good = (n == 1);
            bad  = (n == 0);
          end
          if (good) begin
            m_step = 1; m_lock = 1; m_pat = newpat;
            if (cur == 0) m_sweep = (m_sweep + 1) % 256;
            m_hold = 0; m_stall = 0;
          end
          if (bad) begin
            m_err = 1; m_lock = 0;
            if (m_errc < 15) m_errc++;
            m_hold = 0; m_stall = 0;
          end
          m_pos  = (good && m_pat < 2) ? hibit(cur) : $countones(cur);
          m_prev = cur;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("locked",    32'(locked),    32'(m_lock));
      chk("pat",       32'(pat),       32'(m_pat));
      chk("pos",       32'(pos),       32'(m_pos));
      chk("step",      32'(step),      32'(m_step));
      chk("err",       32'(err),       32'(m_err));
      chk("sweep_cnt", 32'(sweep_cnt), 32'(m_sweep));
      chk("err_cnt",   32'(err_cnt),   32'(m_errc));
      chk("stall",     32'(stall),     32'(m_stall));
    end
  end

  task automatic apply(input logic r, input logic s, input logic [7:0] d);
    reset = r; SS = s; LED8 = d;
    @(posedge clk);
    #2;
  endtask

  task automatic feed(input logic [7:0] d);
    apply(1'b0, 1'b1, d);
  endtask

  logic [7:0] seq_a [9];
  logic [7:0] rnd;
  int exp_stall;

  initial begin
    seq_a = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00, 8'h80, 8'h40};
`ifdef LED_MON_STALL_EN
    exp_stall = 1;
`else
    exp_stall = 0;
`endif
    apply(1'b1, 1'b0, 8'h00);
    apply(1'b1, 1'b0, 8'h00);
    cmp_en = 1'b1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_pat", 32'(pat), 0);
    chk("rst_pos", 32'(pos), 0);
    chk("rst_step", 32'(step), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sweep", 32'(sweep_cnt), 0);
    chk("rst_errc", 32'(err_cnt), 0);
    chk("rst_stall", 32'(stall), 0);

    // Dot right full sweep
    feed(8'h80); chk("t1_hunt80", 32'(locked), 0);
    feed(8'h40); chk("t1_lock", 32'(locked), 1); chk("t1_pat", 32'(pat), 0);
    chk("t1_step", 32'(step), 1); chk("t1_pos40", 32'(pos), 6);
    feed(8'h20); feed(8'h10); feed(8'h08); feed(8'h04); feed(8'h02); feed(8'h01);
    chk("t1_pos01", 32'(pos), 0);
    feed(8'h00); chk("t1_pos00", 32'(pos), 8); chk("t1_sweep", 32'(sweep_cnt), 1);
    feed(8'h80); chk("t1_step80", 32'(step), 1); chk("t1_errc", 32'(err_cnt), 0);

    // Fill right
    apply(1'b1, 1'b0, 8'h00);
    feed(8'h01); chk("t2_hunt01", 32'(locked), 0);
    feed(8'h03); chk("t2_lock", 32'(locked), 1); chk("t2_pat", 32'(pat), 3); chk("t2_pos03", 32'(pos), 2);
    feed(8'h07); feed(8'h0F); feed(8'h1F); feed(8'h3F); feed(8'h7F); feed(8'hFF);
    chk("t2_posFF", 32'(pos), 8);
    feed(8'h00); chk("t2_sweep", 32'(sweep_cnt), 1); chk("t2_pos00", 32'(pos), 0);

    // Illegal step and re-lock from the bad value
    apply(1'b1, 1'b0, 8'h00);
    feed(8'h80); feed(8'h40); feed(8'h20);
    feed(8'h24); chk("t3_err", 32'(err), 1); chk("t3_unlock", 32'(locked), 0);
    chk("t3_errc", 32'(err_cnt), 1); chk("t3_pos24", 32'(pos), 2); chk("t3_pathold", 32'(pat), 0);
    feed(8'h12); chk("t3_relock", 32'(locked), 1); chk("t3_pat", 32'(pat), 0);
    chk("t3_step12", 32'(step), 1); chk("t3_noerr", 32'(err), 0); chk("t3_pos12", 32'(pos), 4);
    feed(8'h09); chk("t3_step09", 32'(step), 1); chk("t3_pos09", 32'(pos), 3);

    // Sample enable low, pauses and stall
    apply(1'b1, 1'b0, 8'h00);
    feed(8'h80); feed(8'h40); feed(8'h20); feed(8'h10);
    for (int i = 0; i < 5; i++) begin
      rnd = 8'($urandom);
      apply(1'b0, 1'b0, rnd);
      chk("t4_ss0_pos", 32'(pos), 4); chk("t4_ss0_step", 32'(step), 0); chk("t4_ss0_lock", 32'(locked), 1);
    end
    for (int i = 0; i < 3; i++) begin
      feed(8'h10); chk("t4_hold_step", 32'(step), 0); chk("t4_hold_err", 32'(err), 0);
    end
    chk("t4_nostall3", 32'(stall), 0);
    feed(8'h10); chk("t4_stall", 32'(stall), 32'(exp_stall)); chk("t4_lockkept", 32'(locked), 1);
    feed(8'h08); chk("t4_step08", 32'(step), 1); chk("t4_stallclr", 32'(stall), 0);
    feed(8'h04);
    apply(1'b1, 1'b1, 8'h08);
    chk("t4_rst_lock", 32'(locked), 0); chk("t4_rst_pos", 32'(pos), 0); chk("t4_rst_step", 32'(step), 0);

    // Fill left, then an error keeps the last pattern
    apply(1'b1, 1'b0, 8'h00);
    feed(8'h80);
    feed(8'hC0); chk("t5_pat", 32'(pat), 2); chk("t5_pos", 32'(pos), 2);
    feed(8'hE0); feed(8'hF0); feed(8'hF8); feed(8'hFC); feed(8'hFE); feed(8'hFF);
    feed(8'h00); chk("t5_sweep", 32'(sweep_cnt), 1);
    feed(8'h80); chk("t5_step80", 32'(step), 1);
    feed(8'h55); chk("t5_err", 32'(err), 1); chk("t5_pathold", 32'(pat), 2);

    // Dot left
    apply(1'b1, 1'b0, 8'h00);
    feed(8'h01); chk("t6_hunt01", 32'(locked), 0);
    feed(8'h02); chk("t6_pat", 32'(pat), 1); chk("t6_pos02", 32'(pos), 1);
    feed(8'h04); feed(8'h08); feed(8'h10); feed(8'h20); feed(8'h40); feed(8'h80);
    feed(8'h00); chk("t6_sweep", 32'(sweep_cnt), 1); chk("t6_pos00", 32'(pos), 8);

    // Error counter saturation
    apply(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 18; i++) feed((i % 2 == 0) ? 8'h5A : 8'h3C);
    chk("t7_errsat", 32'(err_cnt), 15); chk("t7_errpulse", 32'(err), 1);

    // Sweep counter wrap
    apply(1'b1, 1'b0, 8'h00);
    feed(8'h80); feed(8'h40);
    for (int s = 0; s < 256; s++) for (int j = 0; j < 9; j++) feed(seq_a[j]);
    chk("t8_wrap", 32'(sweep_cnt), 0); chk("t8_locked", 32'(locked), 1);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
